// File: rtl/rom_seq_ctrl_pkg.sv
// Shared mode/direction encodings for the ROM address sequencer.
// Mode 2'b11 is reserved and decodes to wrap.
package rom_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_PING    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_PING;
      2'b10:   return MODE_ONESHOT;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running period counter: o_tick is a combinational 1-cycle strobe every CNT_MAX+1 enabled cycles.
// Zero latency from terminal count to tick; i_clr restarts the period and masks a coincident tick.
module period_timer #(
  parameter int unsigned          CNT_W   = 24,
  parameter logic [CNT_W-1:0]     CNT_MAX = CNT_W'(9_999_999)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign o_tick   = i_en & ~i_clr & w_at_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rom_seq_ctrl.sv
// ROM address sequencer: timed/stepped advance in wrap, ping-pong or one-shot order.
// data/data_valid follow each advance by ROM_LAT+1 cycles; no backpressure, key flags are pulses.
module rom_seq_ctrl
  import rom_seq_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          DEPTH   = 256,
  parameter int          DATA_W  = 8,
  parameter logic [23:0] CNT_MAX = 24'd9_999_999,
  parameter int          ROM_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run_flag,
  input  logic              step_flag,
  input  logic              dir_flag,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              running,
  output logic              dir,
  output logic              done
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PREV    = ADDR_W'(DEPTH - 2);

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_dv;
  logic              r_run;
  logic              r_dir;
  logic              r_done;
  logic              r_boot;
  logic [ROM_LAT:0]  r_pipe;

  logic              w_run_tgl;
  logic              w_step;
  logic              w_tick;
  logic              w_adv;
  logic              w_dir_eff;
  logic              w_dir_nxt;
  logic              w_hold;
  logic [ADDR_W-1:0] w_addr_nxt;
  mode_e             w_mode;

  // run_flag is resolved before step_flag so a combined pulse pauses and steps at once.
  assign w_run_tgl = r_run ^ run_flag;
  assign w_step    = step_flag & ~w_run_tgl;
  assign w_adv     = w_tick | w_step;
  assign w_dir_eff = r_dir ^ dir_flag;
  assign w_mode    = decode_mode(mode);

  period_timer #(
    .CNT_W   (24),
    .CNT_MAX (CNT_MAX)
  ) u_timer (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_en    (r_run),
    .i_clr   (run_flag | w_step),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_addr_nxt = r_addr;
    w_dir_nxt  = w_dir_eff;
    w_hold     = 1'b0;
    if (w_adv) begin
      if ({1'b0, r_addr} >= DEPTH_X) begin
        w_addr_nxt = '0;
      end else if (w_dir_eff == DIR_UP) begin
        if (r_addr != LAST) begin
          w_addr_nxt = r_addr + 1'b1;
        end else begin
          case (w_mode)
            MODE_PING:    begin w_addr_nxt = PREV; w_dir_nxt = DIR_DN; end
            MODE_ONESHOT: w_hold = 1'b1;
            default:      w_addr_nxt = '0;
          endcase
        end
      end else begin
        if (r_addr != '0) begin
          w_addr_nxt = r_addr - 1'b1;
        end else begin
          case (w_mode)
            MODE_PING:    begin w_addr_nxt = ADDR_W'(1); w_dir_nxt = DIR_UP; end
            MODE_ONESHOT: w_hold = 1'b1;
            default:      w_addr_nxt = LAST;
          endcase
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_dv   <= 1'b0;
      r_run  <= 1'b1;
      r_dir  <= DIR_UP;
      r_done <= 1'b0;
      r_boot <= 1'b1;
      r_pipe <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      r_dir  <= w_dir_nxt;
      r_run  <= w_hold ? 1'b0 : w_run_tgl;
      r_done <= w_hold;
      r_boot <= 1'b0;
      // r_boot injects one pseudo-advance so word 0 is displayed after reset.
      r_pipe <= {r_pipe[ROM_LAT-1:0], (w_adv & ~w_hold) | r_boot};
      r_dv   <= r_pipe[ROM_LAT];
      if (r_pipe[ROM_LAT]) begin
        r_data <= rom_q;
      end
    end
  end

  assign addr       = r_addr;
  assign data       = r_data;
  assign data_valid = r_dv;
  assign running    = r_run;
  assign dir        = r_dir;
  assign done       = r_done;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Bench for rom_seq_ctrl (DEPTH=6, CNT_MAX=3, ROM_LAT=1, ROM q = addr + 8'h10).
module tb_rom_seq_ctrl;

  localparam int DEPTH = 6;
  localparam int CMAX  = 3;
  localparam int LAT   = 1;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       run_flag  = 1'b0;
  logic       step_flag = 1'b0;
  logic       dir_flag  = 1'b0;
  logic [1:0] mode      = 2'b00;
  logic [7:0] rom_q;
  logic [7:0] addr;
  logic [7:0] data;
  logic       data_valid, running, dir, done;

  rom_seq_ctrl #(
    .ADDR_W (8), .DEPTH (DEPTH), .DATA_W (8),
    .CNT_MAX (24'd3), .ROM_LAT (LAT)
  ) dut (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
    .run_flag (run_flag), .step_flag (step_flag), .dir_flag (dir_flag),
    .mode (mode), .rom_q (rom_q),
    .addr (addr), .data (data), .data_valid (data_valid),
    .running (running), .dir (dir), .done (done)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge sys_clk) rom_q <= addr + 8'h10;

  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] cur_mode = 2'b00;

  // Reference state: positions, direction and a list of pending display events.
  int m_addr, m_dir, m_run, m_cnt, m_done, m_dv, m_data;
  int q_rem[$];
  int q_val[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_addr = 0; m_dir = 0; m_run = 1; m_cnt = 0;
    m_done = 0; m_dv = 0; m_data = 0;
    q_rem.delete(); q_val.delete();
    q_rem.push_back(LAT + 2);
    q_val.push_back(8'h10);
  endtask

  task automatic model_step(input bit rf, input bit sf, input bit df, input int md);
    int new_run, d, na, stp, hold, adv;
    new_run = m_run ^ rf;
    adv = 0;
    if (sf && !new_run) begin
      adv = 1; m_cnt = 0;
    end else if (rf) begin
      m_cnt = 0;
    end else if (m_run) begin
      if (m_cnt == CMAX) begin adv = 1; m_cnt = 0; end
      else m_cnt++;
    end
    d = m_dir ^ int'(df);
    hold = 0; na = m_addr; m_done = 0;
    if (adv) begin
      stp = d ? -1 : 1;
      na  = m_addr + stp;
      if (na < 0 || na >= DEPTH) begin
        case ((md == 3) ? 0 : md)
          0: na = (na + DEPTH) % DEPTH;
          1: begin d = 1 - d; na = m_addr - stp; end
          default: begin hold = 1; na = m_addr; new_run = 0; m_done = 1; end
        endcase
      end
    end
    m_dv = 0;
    for (int i = q_rem.size() - 1; i >= 0; i--) begin
      if (q_rem[i] == 1) begin
        m_dv = 1; m_data = q_val[i];
        q_rem.delete(i); q_val.delete(i);
      end else begin
        q_rem[i] = q_rem[i] - 1;
      end
    end
    if (adv && !hold) begin
      q_rem.push_back(LAT + 1);
      q_val.push_back((na + 16) % 256);
    end
    m_addr = na; m_dir = d; m_run = new_run;
  endtask

  task automatic cmp_model();
    chk("m.addr", int'(addr), m_addr);
    chk("m.data", int'(data), m_data);
    chk("m.dv", int'(data_valid), m_dv);
    chk("m.running", int'(running), m_run);
    chk("m.dir", int'(dir), m_dir);
    chk("m.done", int'(done), m_done);
  endtask

  // Called at a negedge; applies one clock of inputs and checks against the model.
  task automatic cyc(input bit rf, input bit sf, input bit df);
    run_flag = rf; step_flag = sf; dir_flag = df; mode = cur_mode;
    @(posedge sys_clk);
    model_step(rf, sf, df, int'(cur_mode));
    @(negedge sys_clk);
    cmp_model();
    run_flag = 1'b0; step_flag = 1'b0; dir_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    chk("rst.addr", int'(addr), 0);
    chk("rst.data", int'(data), 0);
    chk("rst.dv", int'(data_valid), 0);
    chk("rst.running", int'(running), 1);
    chk("rst.dir", int'(dir), 0);
    chk("rst.done", int'(done), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit       sf;
    bit       df;
    logic [1:0] md;
    int       ea;
    int       ed;
    int       edone;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int n_dv;
    tbl = '{
      '{1, 0, 2'b00, 1, 0, 0}, '{1, 0, 2'b00, 2, 0, 0}, '{0, 1, 2'b00, 2, 1, 0},
      '{1, 0, 2'b00, 1, 1, 0}, '{1, 0, 2'b00, 0, 1, 0}, '{1, 0, 2'b00, 5, 1, 0},
      '{1, 0, 2'b01, 4, 1, 0}, '{1, 1, 2'b01, 5, 0, 0}, '{1, 0, 2'b01, 4, 1, 0},
      '{1, 1, 2'b01, 5, 0, 0}, '{1, 0, 2'b11, 0, 0, 0}, '{1, 0, 2'b10, 1, 0, 0},
      '{1, 1, 2'b10, 0, 1, 0}, '{1, 0, 2'b10, 0, 1, 1}, '{1, 0, 2'b00, 5, 1, 0},
      '{1, 1, 2'b10, 5, 0, 1}, '{1, 0, 2'b01, 4, 1, 0}, '{1, 0, 2'b01, 3, 1, 0},
      '{1, 0, 2'b01, 2, 1, 0}, '{1, 0, 2'b01, 1, 1, 0}, '{1, 0, 2'b01, 0, 1, 0},
      '{0, 1, 2'b01, 0, 0, 0}, '{1, 1, 2'b01, 1, 0, 0}
    };

    @(negedge sys_clk);

    // Wrap, auto-advance every 4 clocks, word 0 shown after reset.
    cur_mode = 2'b00;
    do_reset();
    idle(3);
    chk("boot.dv", int'(data_valid), 1);
    chk("boot.data", int'(data), 8'h10);
    idle(1);
    chk("wrap.addr1", int'(addr), 1);
    idle(2);
    chk("wrap.dv1", int'(data_valid), 1);
    chk("wrap.data1", int'(data), 8'h11);
    idle(18);
    chk("wrap.addr0", int'(addr), 0);

    // Ping-pong bounce at both ends.
    cur_mode = 2'b01;
    do_reset();
    idle(24);
    chk("ping.top.addr", int'(addr), 4);
    chk("ping.top.dir", int'(dir), 1);
    idle(20);
    chk("ping.bot.addr", int'(addr), 1);
    chk("ping.bot.dir", int'(dir), 0);

    // One-shot running down from 2, hold at 0, resume and hold again.
    cur_mode = 2'b10;
    do_reset();
    idle(8);
    cyc(1'b0, 1'b0, 1'b1);
    idle(3);
    chk("os.addr1", int'(addr), 1);
    idle(4);
    chk("os.addr0", int'(addr), 0);
    idle(4);
    chk("os.done", int'(done), 1);
    chk("os.running", int'(running), 0);
    chk("os.hold", int'(addr), 0);
    chk("os.nodv", int'(data_valid), 0);
    idle(1);
    chk("os.done_pulse", int'(done), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("os.resume", int'(running), 1);
    idle(4);
    chk("os.done2", int'(done), 1);
    chk("os.hold2", int'(addr), 0);

    // Pause and single-step; step ignored while running; run+step together.
    cur_mode = 2'b00;
    do_reset();
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pause.running", int'(running), 0);
    chk("pause.addr", int'(addr), 0);
    n_dv = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (data_valid) n_dv++;
      for (int j = 0; j < 9; j++) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (data_valid) n_dv++;
      end
    end
    chk("step.addr", int'(addr), 3);
    chk("step.dv_count", n_dv, 3);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("step_running.addr", int'(addr), 3);
    cyc(1'b1, 1'b1, 1'b0);
    chk("runstep.running", int'(running), 0);
    chk("runstep.addr", int'(addr), 4);

    // dir_flag on the same cycle as a timer advance.
    do_reset();
    idle(15);
    cyc(1'b0, 1'b0, 1'b1);
    chk("diradv.addr", int'(addr), 2);
    chk("diradv.dir", int'(dir), 1);
    cur_mode = 2'b01;
    do_reset();
    idle(23);
    cyc(1'b0, 1'b0, 1'b1);
    chk("pingdir.addr", int'(addr), 4);
    chk("pingdir.dir", int'(dir), 1);

    // Reset one clock after an advance: the in-flight pulse must vanish.
    cur_mode = 2'b00;
    do_reset();
    idle(4);
    do_reset();
    idle(2);
    chk("midrst.nostale", int'(data_valid), 0);
    idle(1);
    chk("midrst.dv", int'(data_valid), 1);
    chk("midrst.data", int'(data), 8'h10);

    // Paused stepping table.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) begin
      cur_mode = tbl[i].md;
      cyc(1'b0, tbl[i].sf, tbl[i].df);
      chk($sformatf("tbl[%0d].addr", i), int'(addr), tbl[i].ea);
      chk($sformatf("tbl[%0d].dir", i), int'(dir), tbl[i].ed);
      chk($sformatf("tbl[%0d].done", i), int'(done), tbl[i].edone);
    end

    // Randomised traffic against the reference model.
    cur_mode = 2'b00;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      if ($urandom_range(39) == 0) cur_mode = 2'($urandom_range(3));
      cyc($urandom_range(24) == 0, $urandom_range(5) == 0, $urandom_range(14) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
